// File: rtl/unidade_controle_exp3.sv
// Moore control unit for the memory-game round: start, move capture, compare,
// advance the step counter, and report hit/miss.
//
// state      | meaning
// INICIAL    | idle, waiting for iniciar
// PREPARACAO | clear the step counter (zera)
// ESPERA     | waiting for a rising edge on jogada
// COMPARA    | sample igual from the datapath
// PROXIMO    | last step? finish : advance counter (conta)
// ACERTOU    | round won (pronto, acertou)
// ERROU      | round lost (pronto, errou)
module unidade_controle_exp3 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       conta,
  output logic       carrega,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    COMPARA    = 4'h4,
    PROXIMO    = 4'h5,
    ACERTOU    = 4'hA,
    ERROU      = 4'hE
  } estado_t;

  estado_t estado_q, estado_d;
  logic    jogada_prev_q;
  logic    jogada_pulse;

  // The flop tracks jogada in every state, so a button held across the
  // return to ESPERA cannot retrigger a comparison.
  assign jogada_pulse = jogada & ~jogada_prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= INICIAL;
      jogada_prev_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      jogada_prev_q <= jogada;
    end
  end

  always_comb begin
    estado_d = estado_q;
    zera     = 1'b0;
    conta    = 1'b0;
    pronto   = 1'b0;
    acertou  = 1'b0;
    errou    = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        zera     = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (jogada_pulse) estado_d = COMPARA;
      end
      COMPARA: begin
        estado_d = igual ? PROXIMO : ERROU;
      end
      PROXIMO: begin
        // Suppress the count on the last step so the counter never wraps.
        if (fim) begin
          estado_d = ACERTOU;
        end else begin
          conta    = 1'b1;
          estado_d = ESPERA;
        end
      end
      ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign carrega   = 1'b0;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp3.sv
// Randomized bench for unidade_controle_exp3: rounds are scored by a monitor
// that counts conta pulses and COMPARA visits and checks each round's outcome.
`timescale 1ns/1ps
module tb_unidade_controle_exp3;

  logic       clock = 1'b0;
  logic       reset_n, iniciar, jogada, igual, fim;
  logic       zera, conta, carrega, pronto, acertou, errou;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit acertou;
    int contas;
    int comparas;
  } exp_t;
  exp_t exp_q[$];

  unidade_controle_exp3 dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fim(fim), .zera(zera), .conta(conta), .carrega(carrega),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: accumulates per-round activity and scores each finished round.
  int  conta_cnt = 0;
  int  cmp_cnt   = 0;
  logic pronto_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      conta_cnt   = 0;
      cmp_cnt     = 0;
      pronto_prev = 1'b0;
    end else begin
      if (zera) begin
        conta_cnt = 0;
        cmp_cnt   = 0;
        chk("zera_flags", int'({pronto, acertou, errou}), 0);
      end
      if (conta) conta_cnt++;
      if (db_estado == 4'h4) cmp_cnt++;
      if (pronto && !pronto_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pronto: got pronto=1 expected no finished round");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acertou", int'(acertou), int'(e.acertou));
          chk("errou", int'(errou), int'(!e.acertou));
          chk("conta_pulses", conta_cnt, e.contas);
          chk("compara_visits", cmp_cnt, e.comparas);
          chk("final_state", int'(db_estado), e.acertou ? 'hA : 'hE);
          chk("carrega", int'(carrega), 0);
        end
      end
      pronto_prev = pronto;
    end
  end

  // One round of len steps; err_at = 0 means every move is correct.
  task automatic run_round(input int len, input int err_at, input bit hold5);
    exp_t e;
    int   h, l;
    bit   last;
    e.acertou  = (err_at == 0);
    e.contas   = (err_at == 0) ? len - 1 : err_at - 1;
    e.comparas = (err_at == 0) ? len : err_at;
    exp_q.push_back(e);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 1; i <= len; i++) begin
      if (err_at != 0 && i > err_at) break;
      last    = (i == len) || (i == err_at);
      igual   = (i != err_at);
      fim     = (i == len);
      iniciar = last ? 1'b0 : 1'($urandom_range(0, 1));
      jogada  = 1'b1;
      h = hold5 ? 5 : int'($urandom_range(1, 5));
      repeat (h) tick();
      jogada = 1'b0;
      l = ((h >= 2) ? 1 : 2) + int'($urandom_range(0, 2));
      if (!last) repeat (l) tick();
    end
    iniciar = 1'b0;
    for (int c = 0; c < 12 && !pronto; c++) tick();
    chk("pronto_reached", int'(pronto), 1);
    // Presses while the round is over must be ignored.
    jogada = 1'b1;
    repeat (2) tick();
    jogada = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
    #3;
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_outs", int'({zera, conta, carrega, pronto, acertou, errou}), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    tick();
    chk("idle_hold", int'(db_estado), 0);

    // Start sequence
    iniciar = 1'b1;
    chk("start_pre", int'(db_estado), 0);
    tick();
    chk("start_prep", int'(db_estado), 1);
    chk("start_zera", int'(zera), 1);
    iniciar = 1'b0;
    tick();
    chk("start_espera", int'(db_estado), 2);
    chk("start_zera_off", int'(zera), 0);
    tick();
    chk("espera_held", int'(db_estado), 2);

    // Asynchronous reset while waiting in ESPERA
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_estado", int'(db_estado), 0);
    chk("async_rst_outs", int'({zera, conta, pronto}), 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", int'(db_estado), 0);

    run_round(16, 0, 1'b0);
    run_round(16, 3, 1'b0);
    run_round(4, 0, 1'b1);
    run_round(1, 0, 1'b0);
    run_round(5, 1, 1'b0);

    // Reset during PROXIMO must kill the pending conta pulse
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    igual = 1'b1; fim = 1'b0; jogada = 1'b1;
    tick();
    chk("mid_compara", int'(db_estado), 4);
    tick();
    chk("mid_proximo_conta", int'(conta), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_conta", int'(conta), 0);
    chk("mid_rst_estado", int'(db_estado), 0);
    jogada = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    repeat (3) tick();
    chk("mid_rst_idle", int'(db_estado), 0);

    for (int r = 0; r < 20; r++) begin
      int len, err;
      len = int'($urandom_range(1, 16));
      err = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : 0;
      run_round(len, err, 1'b0);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
